dcache_bank_arbiter: RTL and testbench

DCACHE_BANK_ARBITER -- requirements
Module: dcache_bank_arbiter

---
 rtl/dcache_bank_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dcache_bank_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_bank_arbiter.sv
// Data-cache bank arbiter: steers one full-line write or up to two reads onto
// BANK_NUM single-port 64-bit SRAM banks, with registered bank controls and in-order read responses.
module dcache_bank_arbiter #(
    parameter int unsigned BANK_NUM      = 4,
    parameter int unsigned IDX_WIDTH     = 7,
    parameter int unsigned MAX_WR_STREAK = 4
) (
    input  logic                               clk,
    input  logic                               s_rst,
    input  logic [1:0]                         rd_valid_i,
    input  logic [1:0][31:0]                   rd_addr_i,
    output logic [1:0]                         rd_ready_o,
    input  logic                               wr_valid_i,
    input  logic [31:0]                        wr_addr_i,
    input  logic [BANK_NUM*64-1:0]             wr_data_i,
    input  logic [BANK_NUM*8-1:0]              wr_strb_i,
    output logic                               wr_ready_o,
    output logic [BANK_NUM-1:0]                bank_en_o,
    output logic [BANK_NUM-1:0]                bank_we_o,
    output logic [BANK_NUM-1:0][IDX_WIDTH-1:0] bank_addr_o,
    output logic [BANK_NUM-1:0][63:0]          bank_wdata_o,
    output logic [BANK_NUM-1:0][7:0]           bank_wstrb_o,
    input  logic [BANK_NUM-1:0][63:0]          bank_rdata_i,
    output logic [1:0]                         rd_resp_valid_o,
    output logic [1:0][63:0]                   rd_resp_data_o
);

    localparam int unsigned OFFSET_WIDTH = $clog2(BANK_NUM * 8);
    localparam int unsigned SEL_W        = OFFSET_WIDTH - 3;
    localparam int unsigned IDX_HI       = OFFSET_WIDTH + IDX_WIDTH;
    localparam int unsigned STREAK_W     = $clog2(MAX_WR_STREAK + 1);

    logic [1:0][SEL_W-1:0]     rd_sel;
    logic [1:0][IDX_WIDTH-1:0] rd_idx;
    logic [IDX_WIDTH-1:0]      wr_idx;
    logic                      unused_addr_bits;

    logic                any_rd;
    logic                streak_full;
    logic                rd_conflict;
    logic                wr_gnt;
    logic [1:0]          rd_gnt;
    logic                rr_q, rr_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic [BANK_NUM-1:0]                bank_en_q, bank_en_d;
    logic [BANK_NUM-1:0]                bank_we_q, bank_we_d;
    logic [BANK_NUM-1:0][IDX_WIDTH-1:0] bank_addr_q, bank_addr_d;
    logic [BANK_NUM-1:0][63:0]          bank_wdata_q, bank_wdata_d;
    logic [BANK_NUM-1:0][7:0]           bank_wstrb_q, bank_wstrb_d;

    logic [1:0]            rsp_v1_q, rsp_v2_q;
    logic [1:0][SEL_W-1:0] rsp_sel1_q, rsp_sel2_q;

    // Address decode: bank select sits just above the 8-byte word offset.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_sel[p] = rd_addr_i[p][OFFSET_WIDTH-1:3];
            rd_idx[p] = rd_addr_i[p][IDX_HI-1:OFFSET_WIDTH];
        end
        wr_idx = wr_addr_i[IDX_HI-1:OFFSET_WIDTH];
    end

    assign unused_addr_bits = ^{rd_addr_i[0][31:IDX_HI], rd_addr_i[0][2:0],
                                rd_addr_i[1][31:IDX_HI], rd_addr_i[1][2:0],
                                wr_addr_i[31:IDX_HI], wr_addr_i[OFFSET_WIDTH-1:0]};

    // Grant decision: the write wins unless it has starved a pending read for MAX_WR_STREAK cycles.
    always_comb begin
        any_rd      = |rd_valid_i;
        streak_full = (streak_q == STREAK_W'(MAX_WR_STREAK));
        wr_gnt      = ~s_rst & wr_valid_i & (~any_rd | ~streak_full);
        rd_conflict = (&rd_valid_i) & (rd_sel[0] == rd_sel[1]) & (rd_idx[0] != rd_idx[1]);
        rd_gnt      = '0;
        rr_d        = rr_q;
        streak_d    = '0;
        if (!s_rst && !wr_gnt) begin
            if (rd_conflict) begin
                rd_gnt[rr_q] = 1'b1;
                rr_d         = ~rr_q;
            end else begin
                rd_gnt = rd_valid_i;
            end
        end
        if (wr_gnt) begin
            streak_d = (any_rd && !streak_full) ? streak_q + STREAK_W'(1) : streak_q;
        end
    end

    assign rd_ready_o = rd_gnt;
    assign wr_ready_o = wr_gnt;

    // Next bank command: a write drives every bank, reads drive only their own bank.
    always_comb begin
        bank_en_d    = '0;
        bank_we_d    = '0;
        bank_addr_d  = '0;
        bank_wdata_d = '0;
        bank_wstrb_d = '0;
        if (wr_gnt) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                bank_en_d[b]    = 1'b1;
                bank_we_d[b]    = 1'b1;
                bank_addr_d[b]  = wr_idx;
                bank_wdata_d[b] = wr_data_i[64*b +: 64];
                bank_wstrb_d[b] = wr_strb_i[8*b +: 8];
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rd_gnt[p]) begin
                    bank_en_d[rd_sel[p]]   = 1'b1;
                    bank_addr_d[rd_sel[p]] = rd_idx[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            rr_q         <= 1'b0;
            streak_q     <= '0;
            bank_en_q    <= '0;
            bank_we_q    <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            bank_wstrb_q <= '0;
            rsp_v1_q     <= '0;
            rsp_v2_q     <= '0;
            rsp_sel1_q   <= '0;
            rsp_sel2_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            streak_q     <= streak_d;
            bank_en_q    <= bank_en_d;
            bank_we_q    <= bank_we_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            bank_wstrb_q <= bank_wstrb_d;
            rsp_v1_q     <= rd_gnt;
            rsp_v2_q     <= rsp_v1_q;
            rsp_sel1_q   <= rd_sel;
            rsp_sel2_q   <= rsp_sel1_q;
        end
    end

    // Reset blanks every output in the same cycle, not only after the next edge.
    assign bank_en_o       = s_rst ? '0 : bank_en_q;
    assign bank_we_o       = s_rst ? '0 : bank_we_q;
    assign bank_addr_o     = s_rst ? '0 : bank_addr_q;
    assign bank_wdata_o    = s_rst ? '0 : bank_wdata_q;
    assign bank_wstrb_o    = s_rst ? '0 : bank_wstrb_q;
    assign rd_resp_valid_o = s_rst ? '0 : rsp_v2_q;

    // SRAM data arrives the cycle after enable, so the response mux is combinational.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_resp_data_o[p] = rd_resp_valid_o[p] ? bank_rdata_i[rsp_sel2_q[p]] : 64'h0;
        end
    end

endmodule

// File: tb/tb_dcache_bank_arbiter.sv
// Directed bench for dcache_bank_arbiter: a cycle-indexed expectation model plus
// hand-computed pins, with a behavioural SRAM answering bank reads.
module tb_dcache_bank_arbiter;

    localparam int unsigned BANK_NUM      = 4;
    localparam int unsigned IDX_WIDTH     = 7;
    localparam int unsigned MAX_WR_STREAK = 4;
    localparam int          NCYC          = 128;
    localparam logic [255:0] WD = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                               s_rst;
    logic [1:0]                         rd_valid;
    logic [1:0][31:0]                   rd_addr;
    logic [1:0]                         rd_ready_o;
    logic                               wr_valid;
    logic [31:0]                        wr_addr;
    logic [BANK_NUM*64-1:0]             wr_data;
    logic [BANK_NUM*8-1:0]              wr_strb;
    logic                               wr_ready_o;
    logic [BANK_NUM-1:0]                bank_en_o;
    logic [BANK_NUM-1:0]                bank_we_o;
    logic [BANK_NUM-1:0][IDX_WIDTH-1:0] bank_addr_o;
    logic [BANK_NUM-1:0][63:0]          bank_wdata_o;
    logic [BANK_NUM-1:0][7:0]           bank_wstrb_o;
    logic [BANK_NUM-1:0][63:0]          bank_rdata;
    logic [1:0]                         rd_resp_valid_o;
    logic [1:0][63:0]                   rd_resp_data_o;

    dcache_bank_arbiter #(
        .BANK_NUM      (BANK_NUM),
        .IDX_WIDTH     (IDX_WIDTH),
        .MAX_WR_STREAK (MAX_WR_STREAK)
    ) dut (
        .clk             (clk),
        .s_rst           (s_rst),
        .rd_valid_i      (rd_valid),
        .rd_addr_i       (rd_addr),
        .rd_ready_o      (rd_ready_o),
        .wr_valid_i      (wr_valid),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .wr_strb_i       (wr_strb),
        .wr_ready_o      (wr_ready_o),
        .bank_en_o       (bank_en_o),
        .bank_we_o       (bank_we_o),
        .bank_addr_o     (bank_addr_o),
        .bank_wdata_o    (bank_wdata_o),
        .bank_wstrb_o    (bank_wstrb_o),
        .bank_rdata_i    (bank_rdata),
        .rd_resp_valid_o (rd_resp_valid_o),
        .rd_resp_data_o  (rd_resp_data_o)
    );

    // Bank contents are a fixed function of (bank, index), so read data identifies its source.
    function automatic logic [63:0] sram_word(input int b, input int idx);
        return {16'hCAFE, 8'(b), 8'(idx), 16'hBEEF, 8'(b), 8'(idx)};
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < BANK_NUM; b++) begin
            bank_rdata[b] <= (bank_en_o[b] && !bank_we_o[b]) ? sram_word(b, int'(bank_addr_o[b]))
                                                             : 64'hDEAD_BEEF_0BAD_F00D;
        end
    end

    logic [1:0]  exp_rrdy  [NCYC];
    logic        exp_wrdy  [NCYC];
    logic        exp_rst   [NCYC];
    logic [3:0]  exp_en    [NCYC];
    logic [3:0]  exp_we    [NCYC];
    int          exp_addr  [NCYC][BANK_NUM];
    logic [63:0] exp_wdata [NCYC][BANK_NUM];
    logic [7:0]  exp_wstrb [NCYC][BANK_NUM];
    logic [1:0]  exp_rv    [NCYC];
    logic [63:0] exp_rdata [NCYC][2];

    int cyc         = -1;
    int m_rr        = 0;
    int m_streak    = 0;
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour for the inputs of the current cycle, scheduled onto later cycles.
    task automatic model_eval();
        int c = cyc;
        int bk [2];
        int ix [2];
        logic [1:0] gr;
        logic wg;
        bit any;
        exp_rst[c]  = s_rst;
        exp_rv[c+2] = 2'b00;
        exp_en[c+1] = 4'h0;
        exp_we[c+1] = 4'h0;
        for (int b = 0; b < BANK_NUM; b++) begin
            exp_addr[c+1][b]  = 0;
            exp_wdata[c+1][b] = 64'h0;
            exp_wstrb[c+1][b] = 8'h0;
        end
        if (s_rst) begin
            exp_rrdy[c] = 2'b00;
            exp_wrdy[c] = 1'b0;
            exp_en[c]   = 4'h0;
            exp_we[c]   = 4'h0;
            exp_rv[c]   = 2'b00;
            exp_rv[c+1] = 2'b00;
            m_rr        = 0;
            m_streak    = 0;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            bk[p] = int'((rd_addr[p] / 8) % BANK_NUM);
            ix[p] = int'((rd_addr[p] / (8 * BANK_NUM)) % (1 << IDX_WIDTH));
        end
        any = (rd_valid != 2'b00);
        wg  = wr_valid && (!any || m_streak < int'(MAX_WR_STREAK));
        gr  = 2'b00;
        if (!wg) begin
            if (rd_valid == 2'b11 && bk[0] == bk[1] && ix[0] != ix[1]) begin
                gr   = (m_rr == 0) ? 2'b01 : 2'b10;
                m_rr = 1 - m_rr;
            end else begin
                gr = rd_valid;
            end
        end
        if (!wg) m_streak = 0;
        else if (any && m_streak < int'(MAX_WR_STREAK)) m_streak++;
        exp_rrdy[c] = gr;
        exp_wrdy[c] = wg;
        if (wg) begin
            exp_en[c+1] = 4'hF;
            exp_we[c+1] = 4'hF;
            for (int b = 0; b < BANK_NUM; b++) begin
                exp_addr[c+1][b]  = int'((wr_addr / (8 * BANK_NUM)) % (1 << IDX_WIDTH));
                exp_wdata[c+1][b] = 64'(wr_data >> (64 * b));
                exp_wstrb[c+1][b] = 8'(wr_strb >> (8 * b));
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (gr[p]) begin
                exp_en[c+1][bk[p]]   = 1'b1;
                exp_addr[c+1][bk[p]] = ix[p];
                exp_rv[c+2][p]       = 1'b1;
                exp_rdata[c+2][p]    = sram_word(bk[p], ix[p]);
            end
        end
    endtask

    task automatic compare();
        int c = cyc;
        bit r = exp_rst[c];
        chk("rd_ready", 256'(rd_ready_o), 256'(exp_rrdy[c]));
        chk("wr_ready", 256'(wr_ready_o), 256'(exp_wrdy[c]));
        chk("bank_en", 256'(bank_en_o), 256'(exp_en[c]));
        chk("bank_we", 256'(bank_we_o), 256'(exp_we[c]));
        for (int b = 0; b < BANK_NUM; b++) begin
            if (r || exp_en[c][b])
                chk($sformatf("bank_addr[%0d]", b), 256'(bank_addr_o[b]),
                    r ? 256'(0) : 256'(exp_addr[c][b]));
            if (r || exp_we[c][b]) begin
                chk($sformatf("bank_wdata[%0d]", b), 256'(bank_wdata_o[b]),
                    r ? 256'(0) : 256'(exp_wdata[c][b]));
                chk($sformatf("bank_wstrb[%0d]", b), 256'(bank_wstrb_o[b]),
                    r ? 256'(0) : 256'(exp_wstrb[c][b]));
            end
        end
        chk("resp_valid", 256'(rd_resp_valid_o), 256'(exp_rv[c]));
        for (int p = 0; p < 2; p++) begin
            if (r || exp_rv[c][p])
                chk($sformatf("resp_data[%0d]", p), 256'(rd_resp_data_o[p]),
                    r ? 256'(0) : 256'(exp_rdata[c][p]));
        end
    endtask

    task automatic apply(input logic r, input logic [1:0] v, input logic [31:0] a0,
                         input logic [31:0] a1, input logic w, input logic [31:0] waddr,
                         input logic [255:0] wdat, input logic [31:0] wstb);
        @(posedge clk);
        #1;
        cyc++;
        s_rst      = r;
        rd_valid   = v;
        rd_addr[0] = a0;
        rd_addr[1] = a1;
        wr_valid   = w;
        wr_addr    = waddr;
        wr_data    = wdat;
        wr_strb    = wstb;
        model_eval();
        @(negedge clk);
        compare();
    endtask

    task automatic rd(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        apply(1'b0, v, a0, a1, 1'b0, 32'h0, 256'h0, 32'h0);
    endtask

    task automatic idle();
        apply(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 256'h0, 32'h0);
    endtask

    initial begin
        for (int c = 0; c < NCYC; c++) begin
            exp_rrdy[c] = 2'b00; exp_wrdy[c] = 1'b0; exp_rst[c] = 1'b0;
            exp_en[c] = 4'h0; exp_we[c] = 4'h0; exp_rv[c] = 2'b00;
            exp_rdata[c][0] = 64'h0; exp_rdata[c][1] = 64'h0;
            for (int b = 0; b < BANK_NUM; b++) begin
                exp_addr[c][b] = 0; exp_wdata[c][b] = 64'h0; exp_wstrb[c][b] = 8'h0;
            end
        end
        s_rst = 1'b1; rd_valid = 2'b00; rd_addr = '0; wr_valid = 1'b0;
        wr_addr = 32'h0; wr_data = '0; wr_strb = '0;

        // Reset with live requests: nothing may be accepted.
        for (int i = 0; i < 3; i++) apply(1'b1, 2'b11, 32'h08, 32'h10, 1'b1, 32'h40, WD, 32'hFFFF_FFFF);
        chk("reset_rd_ready", 256'(rd_ready_o), 256'(0));
        idle();

        // Two reads to different banks in the same cycle.
        rd(2'b11, 32'h08, 32'h10);
        chk("diffbank_ready", 256'(rd_ready_o), 256'(2'b11));
        idle();
        chk("diffbank_en", 256'(bank_en_o), 256'(4'b0110));
        idle();
        chk("diffbank_rv", 256'(rd_resp_valid_o), 256'(2'b11));
        chk("diffbank_d0", 256'(rd_resp_data_o[0]), 256'(64'hCAFE_0100_BEEF_0100));
        chk("diffbank_d1", 256'(rd_resp_data_o[1]), 256'(64'hCAFE_0200_BEEF_0200));

        // Same bank, different index: round-robin alternates.
        rd(2'b11, 32'h0000, 32'h0020);
        chk("conflict_g0", 256'(rd_ready_o), 256'(2'b01));
        rd(2'b11, 32'h0000, 32'h0020);
        chk("conflict_g1", 256'(rd_ready_o), 256'(2'b10));
        rd(2'b11, 32'h0000, 32'h0020);
        chk("conflict_g2", 256'(rd_ready_o), 256'(2'b01));
        chk("conflict_rv0", 256'(rd_resp_valid_o), 256'(2'b01));
        chk("conflict_d0", 256'(rd_resp_data_o[0]), 256'(64'hCAFE_0000_BEEF_0000));
        idle();
        chk("conflict_rv1", 256'(rd_resp_valid_o), 256'(2'b10));
        chk("conflict_d1", 256'(rd_resp_data_o[1]), 256'(64'hCAFE_0001_BEEF_0001));
        idle();
        chk("conflict_rv2", 256'(rd_resp_valid_o), 256'(2'b01));

        // Same bank and index: shared access, broadcast data.
        rd(2'b11, 32'h18, 32'h18);
        chk("shared_ready", 256'(rd_ready_o), 256'(2'b11));
        idle();
        chk("shared_en", 256'(bank_en_o), 256'(4'b1000));
        idle();
        chk("shared_rv", 256'(rd_resp_valid_o), 256'(2'b11));
        chk("shared_d0", 256'(rd_resp_data_o[0]), 256'(64'hCAFE_0300_BEEF_0300));
        chk("shared_d1", 256'(rd_resp_data_o[1]), 256'(64'hCAFE_0300_BEEF_0300));

        // Write streak against a pending read: 4 writes, 1 read, 3 writes.
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 2'b01, 32'h08, 32'h0, 1'b1, 32'h40, WD, 32'hFFFF_FFFF);
            chk("streak_wr", 256'(wr_ready_o), (i == 4) ? 256'(0) : 256'(1));
            chk("streak_rd", 256'(rd_ready_o), (i == 4) ? 256'(1) : 256'(0));
            if (i == 1 || i == 4) chk("streak_we", 256'(bank_we_o), 256'(4'hF));
            if (i == 5) chk("streak_rd_en", 256'(bank_en_o), 256'(4'b0010));
        end
        idle();
        idle();

        // Partial strobes: only bank 0 gets bytes, but every bank is enabled.
        apply(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h40, WD, 32'h0000_00FF);
        idle();
        chk("strb_en", 256'(bank_en_o), 256'(4'hF));
        chk("strb_b0", 256'(bank_wstrb_o[0]), 256'(8'hFF));
        chk("strb_b1", 256'(bank_wstrb_o[1]), 256'(8'h00));
        chk("strb_b2", 256'(bank_wstrb_o[2]), 256'(8'h00));
        chk("strb_b3", 256'(bank_wstrb_o[3]), 256'(8'h00));
        chk("strb_wd0", 256'(bank_wdata_o[0]), 256'(64'h1111_1111_1111_1111));
        for (int b = 0; b < 4; b++) chk("strb_addr", 256'(bank_addr_o[b]), 256'(2));

        // Writes with no read waiting do not build a streak.
        for (int i = 0; i < 5; i++) apply(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h1E0, WD, 32'h0F0F_0F0F);
        apply(1'b0, 2'b10, 32'h0, 32'h38, 1'b1, 32'h1E0, WD, 32'h0F0F_0F0F);
        chk("nostreak_wr", 256'(wr_ready_o), 256'(1));
        idle();

        // A granted write leaves the round-robin pointer alone.
        apply(1'b0, 2'b11, 32'h0000, 32'h0020, 1'b1, 32'h20, WD, 32'hFFFF_FFFF);
        chk("rr_hold_wr", 256'(wr_ready_o), 256'(1));
        rd(2'b11, 32'h0000, 32'h0020);
        chk("rr_hold_rd", 256'(rd_ready_o), 256'(2'b10));
        rd(2'b10, 32'h0, 32'h38);
        chk("single_p1", 256'(rd_ready_o), 256'(2'b10));
        rd(2'b11, 32'h0FE8, 32'h0030);
        rd(2'b11, 32'hFFFF_F008, 32'h0000_1010);
        idle();
        idle();

        // Reset right after an accepted read must drop its response.
        rd(2'b01, 32'h08, 32'h0);
        chk("rst_accept", 256'(rd_ready_o), 256'(2'b01));
        apply(1'b1, 2'b11, 32'h08, 32'h10, 1'b1, 32'h40, WD, 32'hFFFF_FFFF);
        chk("rst_en", 256'(bank_en_o), 256'(0));
        chk("rst_rv", 256'(rd_resp_valid_o), 256'(0));
        idle();
        chk("rst_rv_n2", 256'(rd_resp_valid_o), 256'(0));
        idle();
        chk("rst_rv_n3", 256'(rd_resp_valid_o), 256'(0));
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
